// File: rtl/sgpio_pkg.sv
// SGPIO initiator shared definitions.
// State encoding and frame layout constants.
package sgpio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  localparam int BITS_PER_DRIVE = 3;

  localparam int ACT = 0;
  localparam int LOC = 1;
  localparam int FLT = 2;

endpackage

// File: rtl/sgpio_sclk_gen.sv
// SGPIO clock divider.
// Produces sclk plus one-clk rise/fall strobes.
module sgpio_sclk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC =
    CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tc;

  // Half-period counter; toggle sclk at terminal count
  always_comb begin
    tc       = (div_q == TC);
    rise_stb = run & ~clear & ~sclk_q & tc;
    fall_stb = run & ~clear & sclk_q & tc;
    div_d    = div_q;
    sclk_d   = sclk_q;
    if (clear) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (run) begin
      if (tc) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + CW'(1);
      end
    end
  end

  // Divider and sclk state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/sgpio_initiator.sv
// SGPIO initiator: frames and serialises LED
// state, and collects the returned status stream.
module sgpio_initiator
  import sgpio_pkg::*;
#(
  parameter int DRIVE_NUM = 4,
  parameter int CLK_DIV   = 50,
  parameter int GAP_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [DRIVE_NUM-1:0]   led_active,
  input  logic [DRIVE_NUM-1:0]   led_locate,
  input  logic [DRIVE_NUM-1:0]   led_fault,
  input  logic                   update_req,
  output logic                   update_ack,
  output logic                   sclk,
  output logic                   sload,
  output logic                   sdout,
  input  logic                   sdin,
  output logic [3*DRIVE_NUM-1:0] status_out,
  output logic                   frame_done
);

  localparam int FB = BITS_PER_DRIVE * DRIVE_NUM;
  localparam int NB = FB + GAP_BITS;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] LAST_SH  = BW'(FB - 1);
  localparam logic [BW-1:0] LAST_GAP = BW'(NB - 1);

  state_e          state_q;
  logic [BW-1:0]   bit_q;
  logic [FB-1:0]   shadow_q;
  logic [FB-1:0]   sreg_q, sreg_d;
  logic [FB-1:0]   status_q;
  logic [FB-1:0]   led_frame;
  logic            sload_q, sdout_q;
  logic            ack_q, done_q;
  logic            rise_stb, fall_stb;
  logic            run, clear;

  assign run   = (state_q != IDLE);
  assign clear = (state_q == IDLE);

  sgpio_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (clear),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Reorder LED inputs into frame bit order
  always_comb begin
    led_frame = '0;
    for (int d = 0; d < DRIVE_NUM; d++) begin
      led_frame[BITS_PER_DRIVE*d+ACT] = led_active[d];
      led_frame[BITS_PER_DRIVE*d+LOC] = led_locate[d];
      led_frame[BITS_PER_DRIVE*d+FLT] = led_fault[d];
    end
  end

  // Status shifter: bit 0 enters first, ends at LSB
  always_comb begin
    sreg_d = {sdin, sreg_q[FB-1:1]};
  end

  // Frame FSM. The last gap bit's low half
  // doubles as LOAD plus the lead-in to bit 0,
  // so frame period is exactly NB bit-times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      shadow_q <= '0;
      sreg_q   <= '0;
      status_q <= '0;
      sload_q  <= 1'b0;
      sdout_q  <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sload_q <= 1'b0;
          sdout_q <= 1'b0;
          if (enable) state_q <= LOAD;
        end
        LOAD: begin
          if (update_req) begin
            shadow_q <= led_frame;
            ack_q    <= 1'b1;
          end
          bit_q   <= '0;
          sreg_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (rise_stb) begin
            sload_q <= (bit_q == '0);
            sdout_q <= shadow_q[bit_q];
          end
          if (fall_stb) begin
            sreg_q <= sreg_d;
            bit_q  <= bit_q + BW'(1);
            if (bit_q == LAST_SH) begin
              status_q <= sreg_d;
              done_q   <= 1'b1;
              state_q  <= GAP;
            end
          end
        end
        GAP: begin
          if (rise_stb) begin
            sload_q <= 1'b0;
            sdout_q <= 1'b0;
          end
          if (fall_stb) begin
            if (bit_q == LAST_GAP) begin
              state_q <= enable ? LOAD : IDLE;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
      endcase
    end
  end

  assign sload      = sload_q;
  assign sdout      = sdout_q;
  assign update_ack = ack_q;
  assign frame_done = done_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_sgpio_initiator.sv
// Directed bench for sgpio_initiator.
// DRIVE_NUM=4, CLK_DIV=4, GAP_BITS=4.
module tb_sgpio_initiator;

  localparam int D  = 4;
  localparam int CD = 4;
  localparam int GB = 4;
  localparam int FB = 3 * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [D-1:0]  led_active, led_locate, led_fault;
  logic          update_req;
  logic          update_ack;
  logic          sclk, sload, sdout, sdin;
  logic [FB-1:0] status_out;
  logic          frame_done;

  sgpio_initiator #(
    .DRIVE_NUM (D),
    .CLK_DIV   (CD),
    .GAP_BITS  (GB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .led_active (led_active),
    .led_locate (led_locate),
    .led_fault  (led_fault),
    .update_req (update_req),
    .update_ack (update_ack),
    .sclk       (sclk),
    .sload      (sload),
    .sdout      (sdout),
    .sdin       (sdin),
    .status_out (status_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  int            rise_cyc[64];
  logic          rise_sd[64];
  logic          rise_sl[64];
  int            nrise, nack, ndone, sl_hi;
  int            done_cyc[8];
  logic [FB-1:0] done_st[8];
  logic [FB-1:0] pat;

  // Long run with mid-stream stimulus hooks
  // keyed on sclk rise count.
  task automatic run_cap(input int ncyc);
    logic p;
    int   r;
    nrise = 0; nack = 0; ndone = 0; sl_hi = 0;
    p = sclk;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (update_ack) begin
        nack++;
        update_req = 1'b0;
      end
      if (frame_done) begin
        if (ndone < 8) begin
          done_cyc[ndone] = c;
          done_st[ndone]  = status_out;
        end
        ndone++;
      end
      if (sload) sl_hi++;
      if (sclk && !p) begin
        if (nrise < 64) begin
          rise_cyc[nrise] = c;
          rise_sd[nrise]  = sdout;
          rise_sl[nrise]  = sload;
        end
        r = nrise % 16;
        sdin = (r < FB) ? pat[r] : 1'b0;
        if (nrise == 5) begin
          led_active = 4'b1111;
          led_locate = 4'b0000;
          led_fault  = 4'b0101;
        end
        if (nrise == 20) update_req = 1'b1;
        if (nrise == 37) enable = 1'b0;
        nrise++;
      end
      p = sclk;
    end
  endtask

  task automatic pack(input int base,
                      output logic [15:0] sd,
                      output logic [15:0] sl);
    for (int i = 0; i < 16; i++) begin
      sd[i] = rise_sd[base+i];
      sl[i] = rise_sl[base+i];
    end
  endtask

  task automatic wait_rise(input int budget,
                           output logic ok);
    logic p;
    ok = 1'b0;
    p  = sclk;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sclk && !p) begin
        ok = 1'b1;
        break;
      end
      p = sclk;
    end
  endtask

  logic [15:0] sd, sl;
  logic        act, ok;

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    led_active = '0;
    led_locate = '0;
    led_fault  = '0;
    update_req = 1'b0;
    sdin       = 1'b0;
    pat        = 12'hA5C;

    repeat (3) @(negedge clk);
    chk("rst_outs",
        {sclk, sload, sdout, update_ack, frame_done},
        5'b0);
    chk("rst_status", status_out, 0);

    rst = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      act |= sclk | sload | sdout |
             update_ack | frame_done;
    end
    chk("idle_quiet", act, 0);

    led_active = 4'b0001;
    led_locate = 4'b0010;
    led_fault  = 4'b1000;
    update_req = 1'b1;
    enable     = 1'b1;
    run_cap(650);

    pack(0, sd, sl);
    chk("fA_sdout", sd, 16'h0811);
    chk("fA_sload", sl, 16'h0001);
    pack(16, sd, sl);
    chk("fB_sdout", sd, 16'h0811);
    chk("fB_sload", sl, 16'h0001);
    pack(32, sd, sl);
    chk("fC_sdout", sd, 16'h034D);
    chk("fC_sload", sl, 16'h0001);
    chk("bit_period",
        rise_cyc[1] - rise_cyc[0], 8);
    chk("period_AB",
        rise_cyc[16] - rise_cyc[0], 128);
    chk("period_BC",
        rise_cyc[32] - rise_cyc[16], 128);
    chk("sload_clks", sl_hi, 24);
    chk("ack_count", nack, 2);
    chk("rise_count", nrise, 48);
    chk("done_count", ndone, 3);
    chk("done_time",
        done_cyc[0] - rise_cyc[11], CD);
    chk("status_A", done_st[0], 12'hA5C);
    chk("status_C", done_st[2], 12'hA5C);
    chk("status_hold", status_out, 12'hA5C);
    chk("idle_sclk", sclk, 0);

    led_active = 4'b0001;
    led_locate = 4'b0010;
    led_fault  = 4'b1000;
    update_req = 1'b1;
    enable     = 1'b1;
    sdin       = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_rise(40, ok);
      chk("rise_wait", ok, 1);
    end
    #1 rst = 1'b0;
    #1;
    chk("arst_outs",
        {sclk, sload, sdout, update_ack, frame_done},
        5'b0);
    chk("arst_status", status_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_rise(40, ok);
    chk("post_rst_rise", ok, 1);
    chk("post_rst_sload", sload, 1);
    chk("post_rst_sdout", sdout, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
